// File: rtl/valu_seq.sv
// rtl/valu_seq.sv - Vector ALU command sequencer.
// Steps a register group through read/exec/writeback beats around an external combinational vALU.
module valu_seq #(
  parameter int VLEN = 128,
  parameter int NREG = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [2:0]               cmd_sew,
  input  logic [1:0]               cmd_lmul,
  input  logic [$clog2(NREG)-1:0]  cmd_vs1,
  input  logic [$clog2(NREG)-1:0]  cmd_vs2,
  input  logic [$clog2(NREG)-1:0]  cmd_vd,
  input  logic [VLEN-1:0]          cmd_scalar,
  output logic [$clog2(NREG)-1:0]  rf_rd_addr1,
  output logic [$clog2(NREG)-1:0]  rf_rd_addr2,
  input  logic [VLEN-1:0]          rf_rd_data1,
  input  logic [VLEN-1:0]          rf_rd_data2,
  output logic [VLEN-1:0]          alu_in1,
  output logic [VLEN-1:0]          alu_in2,
  output logic [VLEN-1:0]          alu_scalar,
  output logic [2:0]               alu_op,
  output logic [2:0]               alu_sew,
  input  logic [VLEN-1:0]          alu_result,
  output logic                     rf_wr_en,
  output logic [$clog2(NREG)-1:0]  rf_wr_addr,
  output logic [VLEN-1:0]          rf_wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int AW = $clog2(NREG);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_READ  = 3'd2,
    S_EXEC  = 3'd3,
    S_WB    = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_op;
  logic [2:0]        r_sew;
  logic [1:0]        r_lmul;
  logic [AW-1:0]     r_vs1;
  logic [AW-1:0]     r_vs2;
  logic [AW-1:0]     r_vd;
  logic [VLEN-1:0]   r_scalar;
  logic [VLEN-1:0]   r_result;
  logic [1:0]        r_k;

  logic [1:0]        w_nm1;
  logic              w_illegal;
  logic              w_last;
  logic              w_accept;
  logic [AW-1:0]     w_k;

  // N-1 doubles as the alignment mask for the group base indices.
  always_comb begin
    case (r_lmul)
      2'd0:    w_nm1 = 2'd0;
      2'd1:    w_nm1 = 2'd1;
      default: w_nm1 = 2'd3;
    endcase
  end

  assign w_illegal = (r_op[2:1] == 2'b11) || (r_sew > 3'd4) || (r_lmul == 2'd3) ||
                     (|(r_vs1[1:0] & w_nm1)) || (|(r_vs2[1:0] & w_nm1)) ||
                     (|(r_vd[1:0] & w_nm1));
  assign w_last    = (r_k == w_nm1);
  assign w_k       = AW'(r_k);
  assign w_accept  = (r_state == S_IDLE) && cmd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_sew    <= '0;
      r_lmul   <= '0;
      r_vs1    <= '0;
      r_vs2    <= '0;
      r_vd     <= '0;
      r_scalar <= '0;
      r_result <= '0;
      r_k      <= '0;
    end else begin
      if (w_accept) begin
        r_op     <= cmd_op;
        r_sew    <= cmd_sew;
        r_lmul   <= cmd_lmul;
        r_vs1    <= cmd_vs1;
        r_vs2    <= cmd_vs2;
        r_vd     <= cmd_vd;
        r_scalar <= cmd_scalar;
      end
      if (r_state == S_CHECK) begin
        r_k <= '0;
      end
      if (r_state == S_EXEC) begin
        r_result <= alu_result;
      end
      if ((r_state == S_WB) && !w_last) begin
        r_k <= r_k + 2'd1;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    cmd_ready   = 1'b0;
    busy        = (r_state != S_IDLE);
    done        = 1'b0;
    err         = 1'b0;
    rf_rd_addr1 = '0;
    rf_rd_addr2 = '0;
    alu_in1     = '0;
    alu_in2     = '0;
    alu_scalar  = '0;
    alu_op      = '0;
    alu_sew     = '0;
    rf_wr_en    = 1'b0;
    rf_wr_addr  = '0;
    rf_wr_data  = '0;

    if (r_state != S_IDLE) begin
      alu_op     = r_op;
      alu_sew    = r_sew;
      alu_scalar = r_scalar;
    end

    case (r_state)
      S_IDLE: begin
        // Gate with rst_n so ready stays low throughout reset.
        cmd_ready = rst_n;
        if (cmd_valid) begin
          w_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_illegal) begin
          err    = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_next = S_READ;
        end
      end
      S_READ: begin
        rf_rd_addr1 = r_vs1 + w_k;
        rf_rd_addr2 = r_vs2 + w_k;
        w_next      = S_EXEC;
      end
      S_EXEC: begin
        alu_in1 = rf_rd_data1;
        alu_in2 = rf_rd_data2;
        w_next  = S_WB;
      end
      S_WB: begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = r_vd + w_k;
        rf_wr_data = r_result;
        if (w_last) begin
          done   = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_next = S_READ;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_valu_seq.sv
// tb/tb_valu_seq.sv - Scoreboard bench for valu_seq with register-file and vALU models.
module tb_valu_seq;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [2:0]   cmd_sew;
  logic [1:0]   cmd_lmul;
  logic [4:0]   cmd_vs1, cmd_vs2, cmd_vd;
  logic [127:0] cmd_scalar;
  logic [4:0]   rf_rd_addr1, rf_rd_addr2;
  logic [127:0] rf_rd_data1, rf_rd_data2;
  logic [127:0] alu_in1, alu_in2, alu_scalar;
  logic [2:0]   alu_op, alu_sew;
  logic [127:0] alu_result;
  logic         rf_wr_en;
  logic [4:0]   rf_wr_addr;
  logic [127:0] rf_wr_data;
  logic         busy, done, err;

  valu_seq dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_sew(cmd_sew), .cmd_lmul(cmd_lmul),
    .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vd(cmd_vd), .cmd_scalar(cmd_scalar),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_scalar(alu_scalar),
    .alu_op(alu_op), .alu_sew(alu_sew), .alu_result(alu_result),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [4:0]   addr;
    logic [127:0] data;
    int           cyc;
    bit           last;
  } wr_t;

  logic [127:0] rf  [32];
  logic [127:0] mdl [32];
  wr_t          wq[$];
  int           eq[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  int           next_accept = 0;
  bit           have_prev = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Elementwise vALU: 0 add, 1 and, 2 sub, 3 or, 4 xor, 5 multiply by scalar element.
  function automatic logic [127:0] valu_f(input logic [2:0] op, input logic [2:0] sew,
                                          input logic [127:0] a, input logic [127:0] b,
                                          input logic [127:0] s);
    logic [127:0] m, r, ea, eb, es, e;
    int ew;
    r = '0;
    if (sew > 3'd4) return r;
    ew = 8 << sew;
    m = (ew == 128) ? {128{1'b1}} : ((128'd1 << ew) - 128'd1);
    es = s & m;
    for (int i = 0; i < 128 / ew; i++) begin
      ea = (a >> (i * ew)) & m;
      eb = (b >> (i * ew)) & m;
      case (op)
        3'd0: e = ea + eb;
        3'd1: e = ea & eb;
        3'd2: e = ea - eb;
        3'd3: e = ea | eb;
        3'd4: e = ea ^ eb;
        3'd5: e = ea * es;
        default: e = '0;
      endcase
      r = r | ((e & m) << (i * ew));
    end
    return r;
  endfunction

  assign alu_result = valu_f(alu_op, alu_sew, alu_in1, alu_in2, alu_scalar);

  always @(posedge clk) begin
    rf_rd_data1 <= rf[rf_rd_addr1];
    rf_rd_data2 <= rf[rf_rd_addr2];
    if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t w;
    int  ec;
    if (rf_wr_en) begin
      if (wq.size() == 0) begin
        check("unexpected_write", rf_wr_en, 1'b0);
      end else begin
        w = wq.pop_front();
        check("wr_addr", rf_wr_addr, w.addr);
        check("wr_data", rf_wr_data, w.data);
        check("wr_cycle", cyc, w.cyc);
        check("done_with_write", done, w.last);
      end
    end else if (done) begin
      check("done_without_write", done, 1'b0);
    end
    if (err) begin
      if (eq.size() == 0) begin
        check("unexpected_err", err, 1'b0);
      end else begin
        ec = eq.pop_front();
        check("err_cycle", cyc, ec);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [2:0] sew, input logic [1:0] lmul,
                       input logic [4:0] vs1, input logic [4:0] vs2, input logic [4:0] vd,
                       input logic [127:0] scalar, input bit b2b, input int max_beats,
                       output int e);
    int n, nb;
    bit bad;
    logic [127:0] d;
    @(negedge clk);
    cmd_op = op; cmd_sew = sew; cmd_lmul = lmul;
    cmd_vs1 = vs1; cmd_vs2 = vs2; cmd_vd = vd; cmd_scalar = scalar;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", cmd_ready, 1'b1);
      cmd_valid = 1'b0;
      have_prev = 0;
      e = cyc;
      return;
    end
    @(posedge clk);
    #1;
    e = cyc;
    if (b2b && have_prev) check("accept_cycle", e, next_accept);
    nb = 1 << lmul;
    bad = (op >= 3'd6) || (sew > 3'd4) || (lmul == 2'd3) ||
          (int'(vs1) % nb != 0) || (int'(vs2) % nb != 0) || (int'(vd) % nb != 0);
    if (bad) begin
      eq.push_back(e);
      next_accept = e + 2;
    end else begin
      for (int k = 0; k < nb; k++) begin
        if (max_beats == 0 || k < max_beats) begin
          d = valu_f(op, sew, mdl[int'(vs1) + k], mdl[int'(vs2) + k], scalar);
          mdl[int'(vd) + k] = d;
          wq.push_back('{addr: 5'(int'(vd) + k), data: d, cyc: e + 3 * k + 3, last: (k == nb - 1)});
        end
      end
      next_accept = e + 3 * nb + 2;
    end
    have_prev = 1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || wq.size() != 0 || eq.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 1'b0);
    have_prev = 0;
  endtask

  initial begin
    int e;
    logic [127:0] src [4];
    logic [127:0] exp_v, o6, o7, o8, o9;
    logic [2:0] op, sew;
    logic [1:0] lmul;
    logic [4:0] b1, b2, bd;
    int nb;

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0; cmd_sew = '0; cmd_lmul = '0;
    cmd_vs1 = '0; cmd_vs2 = '0; cmd_vd = '0; cmd_scalar = '0;
    for (int i = 0; i < 32; i++) begin
      rf[i] = {$urandom, $urandom, $urandom, $urandom};
      mdl[i] = rf[i];
    end
    rf[2] = {16{8'h01}}; mdl[2] = rf[2];
    rf[3] = {16{8'h02}}; mdl[3] = rf[3];
    for (int i = 0; i < 4; i++) begin
      rf[8 + i] = {$urandom, $urandom, $urandom, $urandom};
      mdl[8 + i] = rf[8 + i];
      src[i] = rf[8 + i];
    end

    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_en", rf_wr_en, 1'b0);
    check("rst_alu_op", alu_op, 3'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", cmd_ready, 1'b1);

    issue(3'd0, 3'd0, 2'd0, 5'd2, 5'd3, 5'd4, 128'd0, 1'b0, 0, e);
    issue(3'd0, 3'd0, 2'd1, 5'd3, 5'd4, 5'd6, 128'd0, 1'b1, 0, e);
    issue(3'd6, 3'd0, 2'd0, 5'd0, 5'd0, 5'd0, 128'd0, 1'b1, 0, e);
    issue(3'd0, 3'd5, 2'd0, 5'd0, 5'd1, 5'd2, 128'd0, 1'b1, 0, e);
    issue(3'd5, 3'd2, 2'd2, 5'd8, 5'd16, 5'd12, 128'd3, 1'b1, 0, e);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle();
    check("sc1_reg4", rf[4], {16{8'h03}});
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) exp_v[32 * j +: 32] = 32'(src[i][32 * j +: 32] * 3);
      check("sc2_scaled", rf[12 + i], exp_v);
    end

    o6 = rf[6]; o7 = rf[7]; o8 = rf[8]; o9 = rf[9];
    issue(3'd2, 3'd3, 2'd1, 5'd6, 5'd8, 5'd6, 128'd0, 1'b0, 0, e);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle();
    check("inplace_reg6", rf[6], {o6[127:64] - o8[127:64], o6[63:0] - o8[63:0]});
    check("inplace_reg7", rf[7], {o7[127:64] - o9[127:64], o7[63:0] - o9[63:0]});

    issue(3'd0, 3'd0, 2'd1, 5'd10, 5'd12, 5'd14, 128'd0, 1'b0, 1, e);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int n = 0; n < 20 && cyc != e + 4; n++) @(negedge clk);
    check("second_read_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", cmd_ready, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_wr_en", rf_wr_en, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_err", err, 1'b0);
    check("midrst_rd_addr1", rf_rd_addr1, 5'd0);
    check("midrst_wr_data", rf_wr_data, 128'd0);
    check("midrst_alu_scalar", alu_scalar, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_midrst", cmd_ready, 1'b1);
    have_prev = 0;

    for (int t = 0; t < 40; t++) begin
      op   = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
      sew  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      lmul = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      nb   = 1 << lmul;
      b1   = 5'($urandom_range(0, 31) & ~(nb - 1));
      b2   = 5'($urandom_range(0, 31) & ~(nb - 1));
      bd   = 5'($urandom_range(0, 31) & ~(nb - 1));
      if ($urandom_range(0, 7) == 0) b2 = 5'($urandom_range(0, 31));
      issue(op, sew, lmul, b1, b2, bd, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 0, e);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle();
    check("write_queue_drained", 128'(wq.size()), 128'd0);
    check("err_queue_drained", 128'(eq.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/valu_seq.md
VALU_SEQ -- requirements
Module: valu_seq

Interface
REQ-001 SHALL have parameter VLEN, default 128, vector register width in bits.
REQ-002 SHALL have parameter NREG, default 32, number of architectural vector registers.
REQ-003 SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  input  1  sole clock, all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted on cmd_valid&&cmd_ready.
- cmd_op  input  3  ALU op code, same encoding as vALU valu_op.
- cmd_sew  input  3  element width code, 0..4 = 8..128 bit.
- cmd_lmul  input  2  group size code, 0/1/2 = 1/2/4 registers, 3 illegal.
- cmd_vs1, cmd_vs2, cmd_vd  input  5 each  register group base indices.
- cmd_scalar  input  VLEN  scalar operand.
- rf_rd_addr1, rf_rd_addr2  output  5 each  register-file read addresses; data returns one cycle later.
- rf_rd_data1, rf_rd_data2  input  VLEN each  register-file read data.
- alu_in1, alu_in2, alu_scalar  output  VLEN each  to vALU reg_in1/reg_in2/reg_scalar_in.
- alu_op, alu_sew  output  3 each  to vALU valu_op/SEW.
- alu_result  input  VLEN  from vALU reg_dest, combinational.
- rf_wr_en  output  1  register-file write strobe.
- rf_wr_addr  output  5  write address.
- rf_wr_data  output  VLEN  write data.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse, command completed.
- err  output  1  one-cycle pulse, command rejected.

Function
REQ-004 SHALL implement FSM states IDLE, CHECK, READ, EXEC, WB.
REQ-005 SHALL drive cmd_ready=1 only in IDLE; on accept, latch all cmd_* fields and go to CHECK.
REQ-006 CHECK SHALL flag illegal and return to IDLE with err=1 for exactly one cycle when any of these holds: cmd_op is 110 or 111; cmd_sew>4; cmd_lmul=3; any base index not a multiple of N=2^lmul.
REQ-007 A rejected command SHALL produce no rf_wr_en and no done.
REQ-008 A legal command SHALL go from CHECK to READ with beat counter k=0.
REQ-009 READ SHALL drive rf_rd_addr1=vs1+k and rf_rd_addr2=vs2+k; in all other states these outputs SHALL be 0.
REQ-010 EXEC SHALL drive alu_in1=rf_rd_data1 and alu_in2=rf_rd_data2, and SHALL register alu_result into the write-data register at the end of the cycle.
REQ-011 alu_in1 and alu_in2 SHALL be 0 outside EXEC.
REQ-012 alu_op, alu_sew and alu_scalar SHALL equal the latched command fields throughout the command, and SHALL be 0 in IDLE.
REQ-013 WB SHALL assert rf_wr_en=1 for one cycle with rf_wr_addr=vd+k and rf_wr_data equal to the registered result.
REQ-014 After WB, if k<N-1 the FSM SHALL increment k and go to READ; otherwise it SHALL assert done in that same WB cycle and go to IDLE.
REQ-015 Latency: for a legal command accepted at edge 0, the first rf_wr_en SHALL be in cycle 4, the last in cycle 3N+1, and cmd_ready SHALL be high again in cycle 3N+2.
REQ-016 Because groups are aligned, vd and vs groups are identical or disjoint; beat k SHALL be read before it is written, so in-place operations are exact.
REQ-017 Back-to-back commands SHALL be accepted with no extra gap beyond REQ-015.
REQ-018 cmd_valid held high while busy SHALL NOT be accepted, and latched fields SHALL NOT change.
REQ-019 The beat counter SHALL be 2 bits and SHALL never wrap within a command, because N≤4.

Reset
REQ-020 rst_n low SHALL asynchronously force IDLE, k=0, and clear all latched fields and the result register.
REQ-021 While rst_n is low, cmd_ready, busy, done, err and rf_wr_en SHALL be 0 and all address/data outputs SHALL be 0; a command in flight SHALL be abandoned with no further writes.
REQ-022 cmd_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-023 The bench SHALL cover the following scenarios:
- op=000, sew=0, lmul=0, vs1=2 (bytes 0x01), vs2=3 (bytes 0x02), vd=4 -> single write to reg 4 of 0x0303..03 in cycle 4, done in cycle 4.
- op=101, sew=2, lmul=2, vs1=8, vd=12, scalar=3 -> writes to regs 12..15 in cycles 4, 7, 10, 13, each word = 3 × source word, done in cycle 13.
- lmul=1, vs1=3 (misaligned) -> err pulse in cycle 1, no rf_wr_en, cmd_ready in cycle 2.
- op=110 or sew=5 -> err pulse, no writes.
- In-place op=010, lmul=1, vs1=vd=6, vs2=8 -> regs 6 and 7 hold differences of their original contents.
- rst_n pulled low during the second READ of an lmul=1 command -> exactly one write, no done, cmd_ready=1 after release.
